pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage RV32 pipeline: it generates the stall, flush and freeze enables for the PC, IF/ID,
//  ID/EX, EX/MEM and MEM/WB registers. It sits beside the main decoder and reads decoded ID/EX/MEM fields

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 64 ++++++
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: opcode constants, hazard-controller states
// and operand-forwarding select encodings.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational register-dependency compare between the ID sources and the
// EX/MEM/WB destinations; yields RAW/load-use flags and forwarding selects.
module hazard_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic                  raw_ex,
    output logic                  raw_mem,
    output logic                  load_use,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);
    import riscv_pkg::*;

    // x0 is hard-wired zero, so it never creates a dependency
    function automatic logic hit(input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] rs,
                                 input logic                  use_rs);
        return use_rs && (rd != '0) && (rd == rs);
    endfunction

    logic ex_hit;
    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;

    always_comb begin
        ex_hit    = hit(ex_rd, id_rs1, id_use_rs1) || hit(ex_rd, id_rs2, id_use_rs2);
        mem_hit_a = hit(mem_rd, id_rs1, id_use_rs1);
        mem_hit_b = hit(mem_rd, id_rs2, id_use_rs2);
        wb_hit_a  = hit(wb_rd, id_rs1, id_use_rs1);
        wb_hit_b  = hit(wb_rd, id_rs2, id_use_rs2);

        raw_ex   = ex_reg_write && ex_hit;
        raw_mem  = mem_reg_write && (mem_hit_a || mem_hit_b);
        load_use = ex_mem_read && ex_hit;

        fwd_a = FWD_REGFILE;
        if (mem_reg_write && mem_hit_a) begin
            fwd_a = FWD_EXMEM;
        end else if (wb_reg_write && wb_hit_a) begin
            fwd_a = FWD_MEMWB;
        end

        fwd_b = FWD_REGFILE;
        if (mem_reg_write && mem_hit_b) begin
            fwd_b = FWD_EXMEM;
        end else if (wb_reg_write && wb_hit_b) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage RV32 pipeline sequencer: stall/flush/freeze enables, memory timeout
// flag and perf counters. Define FORWARDING_EN to enable operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    import riscv_pkg::*;

    localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic       raw_ex;
    logic       raw_mem;
    logic       load_use;
    logic [1:0] det_fwd_a;
    logic [1:0] det_fwd_b;
    logic       stall_req;
    logic       mem_wait;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .raw_ex       (raw_ex),
        .raw_mem      (raw_mem),
        .load_use     (load_use),
        .fwd_a        (det_fwd_a),
        .fwd_b        (det_fwd_b)
    );

`ifdef FORWARDING_EN
    logic unused_raw;
    assign stall_req  = load_use;
    assign unused_raw = raw_ex ^ raw_mem;
    assign fwd_a      = rst_n ? det_fwd_a : FWD_REGFILE;
    assign fwd_b      = rst_n ? det_fwd_b : FWD_REGFILE;
`else
    // Without bypass paths the ID instruction waits until the producer reaches WB
    logic unused_fwd;
    assign stall_req  = raw_ex | raw_mem;
    assign unused_fwd = ^{load_use, det_fwd_a, det_fwd_b};
    assign fwd_a      = FWD_REGFILE;
    assign fwd_b      = FWD_REGFILE;
`endif

    assign mem_wait = dmem_req && !dmem_ready;

    always_comb begin
        state_d     = RUN;
        wait_cnt_d  = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = mem_err_q;
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;

        if (mem_wait) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            state_d    = MEM_WAIT;
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d == WAIT_MAX) begin
                mem_err_d = 1'b1;
            end
        end else if (state_q != FLUSH) begin
            // The cycle after a flush holds a bubble in EX, so dependency checks are masked
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = FLUSH;
                if (flush_cnt_q != '1) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end else if (stall_req) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                state_d    = LU_STALL;
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
        end

        if (!rst_n) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; expectations adapt to FORWARDING_EN.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RW  = 5;
    localparam int unsigned CW  = 3;
    localparam int unsigned TMO = 4;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_STALL = 5'b00111;
    localparam logic [1:0] FL_NONE  = 2'b00;
    localparam logic [1:0] FL_BOTH  = 2'b11;
    localparam logic [1:0] FL_IDEX  = 2'b01;

    typedef struct packed {
        logic [4:0]    en;
        logic [1:0]    fl;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          err;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic          ex_branch_taken, dmem_req, dmem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, mem_err;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    obs_t  obs;
    obs_t  exp_q[$];
    string name_q[$];
    obs_t  exp_cur;
    string name_cur;
    int unsigned checks = 0;
    int unsigned errors = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .CNT_W      (CW),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                  fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt};

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_cur  = exp_q.pop_front();
            name_cur = name_q.pop_front();
            checks++;
            if (obs !== exp_cur) begin
                errors++;
                $display("FAIL %s: got en=%b fl=%b fwd=%b/%b err=%b stall=%0d flush=%0d, expected en=%b fl=%b fwd=%b/%b err=%b stall=%0d flush=%0d",
                         name_cur, obs.en, obs.fl, obs.fa, obs.fb, obs.err, obs.sc, obs.fc,
                         exp_cur.en, exp_cur.fl, exp_cur.fa, exp_cur.fb, exp_cur.err, exp_cur.sc, exp_cur.fc);
            end
        end
    end

    function automatic obs_t mk(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic err, input int sc, input int fc);
        return {en, fl, fa, fb, err, CW'(sc), CW'(fc)};
    endfunction

    // Queue the expectation for the current cycle, then advance to just after the next edge
    task automatic step(input obs_t e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        step(mk(EN_NONE, FL_BOTH, 2'b00, 2'b00, 1'b0, 0, 0), "reset_outputs");
        rst_n = 1'b1;
    endtask

    task automatic set_load_use();
        ex_rd = 5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        id_rs1 = 5; id_rs2 = 1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "run_idle");
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use();
        step(mk(EN_STALL, FL_IDEX, 2'b00, 2'b00, 1'b0, 0, 0), "lu_stall");
        ex_rd = 0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_rd = 5; mem_reg_write = 1'b1;
        step(FWD ? mk(EN_ALL, FL_NONE, 2'b10, 2'b00, 1'b0, 1, 0)
                 : mk(EN_STALL, FL_IDEX, 2'b00, 2'b00, 1'b0, 1, 0), "lu_load_in_mem");
        mem_rd = 0; mem_reg_write = 1'b0; wb_rd = 5; wb_reg_write = 1'b1;
        step(FWD ? mk(EN_ALL, FL_NONE, 2'b01, 2'b00, 1'b0, 1, 0)
                 : mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 2, 0), "lu_load_in_wb");
        checks++;
        if (stall_cnt !== CW'(FWD ? 1 : 2)) begin
            errors++;
            $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, FWD ? 1 : 2);
        end
    endtask

    task automatic test_x0_no_hazard();
        apply_reset();
        ex_rd = 0; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        id_rs1 = 0; id_rs2 = 1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "x0_load_use");
        ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1'b0;
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "rs1_not_used");
        ex_rd = 0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        mem_rd = 0; mem_reg_write = 1'b1; id_rs1 = 0; id_use_rs1 = 1'b1;
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "x0_in_mem");
        checks++;
        if (stall_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL x0_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_branch_load_use();
        apply_reset();
        set_load_use();
        ex_branch_taken = 1'b1;
        step(mk(EN_ALL, FL_BOTH, 2'b00, 2'b00, 1'b0, 0, 0), "branch_wins");
        ex_branch_taken = 1'b0;
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 1), "flush_masks_raw");
        idle();
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 1), "after_flush");
        checks++;
        if (flush_cnt !== CW'(1) || stall_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL branch_counters: got flush=%0d stall=%0d expected flush=1 stall=0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i == 1);
            step(mk(EN_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "mem_wait_freeze");
        end
        ex_branch_taken = 1'b0; dmem_ready = 1'b1;
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "mem_ready_cycle");
        idle();
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "mem_exit_run");
        checks++;
        if (flush_cnt !== CW'(0) || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_side: got flush=%0d err=%b expected flush=0 err=0", flush_cnt, mem_err);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(mk(EN_NONE, FL_NONE, 2'b00, 2'b00, (i >= 5), 0, 0), "timeout_wait");
        end
        dmem_ready = 1'b1;
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b1, 0, 0), "timeout_ready");
        idle();
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b1, 0, 0), "mem_err_sticky");
    endtask

    task automatic test_raw_forward();
        apply_reset();
        ex_rd = 7; ex_reg_write = 1'b1;
        id_rs1 = 7; id_rs2 = 7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        step(FWD ? mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0)
                 : mk(EN_STALL, FL_IDEX, 2'b00, 2'b00, 1'b0, 0, 0), "raw_ex");
        ex_rd = 0; ex_reg_write = 1'b0;
        mem_rd = 7; mem_reg_write = 1'b1; wb_rd = 7; wb_reg_write = 1'b1;
        step(FWD ? mk(EN_ALL, FL_NONE, 2'b10, 2'b10, 1'b0, 0, 0)
                 : mk(EN_STALL, FL_IDEX, 2'b00, 2'b00, 1'b0, 1, 0), "exmem_priority");
        mem_rd = 0; mem_reg_write = 1'b0;
        step(FWD ? mk(EN_ALL, FL_NONE, 2'b01, 2'b01, 1'b0, 0, 0)
                 : mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 2, 0), "memwb_only");
    endtask

    task automatic test_saturation();
        apply_reset();
        set_load_use();
        for (int k = 0; k < 9; k++) begin
            step(mk(EN_STALL, FL_IDEX, 2'b00, 2'b00, 1'b0, (k > 7) ? 7 : k, 0), "stall_saturate");
        end
        checks++;
        if (stall_cnt !== '1) begin
            errors++;
            $display("FAIL stall_sat_final: got %0d expected %0d", stall_cnt, (1 << CW) - 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        ex_branch_taken = 1'b1;
        step(mk(EN_ALL, FL_BOTH, 2'b00, 2'b00, 1'b0, 0, 0), "pre_branch");
        ex_branch_taken = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
        step(mk(EN_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 1), "pre_wait1");
        step(mk(EN_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 1), "pre_wait2");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} !== 7'b0000011
            || flush_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL async_reset_now: got en=%b fl=%b%b flush=%0d expected en=00000 fl=11 flush=0",
                     {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, ifid_flush, idex_flush, flush_cnt);
        end
        step(mk(EN_NONE, FL_BOTH, 2'b00, 2'b00, 1'b0, 0, 0), "reset_in_wait");
        rst_n = 1'b1;
        idle();
        step(mk(EN_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 0, 0), "run_after_reset");
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_x0_no_hazard();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_raw_forward();
        test_saturation();
        test_reset_mid_wait();
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
